// File: rtl/ahb_bm_pkg.sv
// ============================================================================
// ahb_bm_pkg : shared AHB encodings, input-stage state enum and region defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_bm_pkg;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_busy   = 2'b01;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [1:0] c_htrans_seq    = 2'b11;

    localparam logic       c_hresp_okay    = 1'b0;
    localparam logic       c_hresp_error   = 1'b1;

    localparam logic [2:0] c_hburst_single = 3'b000;

    localparam logic [31:0] c_port0_base = 32'h2000_0000;
    localparam logic [31:0] c_port0_mask = 32'hF000_0000;
    localparam logic [31:0] c_port1_base = 32'h4000_0000;
    localparam logic [31:0] c_port1_mask = 32'hF000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ism_state_e;

endpackage

`default_nettype wire

// File: rtl/ahb_addr_decode_dma.sv
// ============================================================================
// ahb_addr_decode_dma : address to output-port decode, port 0 has priority
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_addr_decode_dma
    import ahb_bm_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PORT0_BASE = ADDR_WIDTH'(c_port0_base),
    parameter logic [ADDR_WIDTH-1:0] PORT0_MASK = ADDR_WIDTH'(c_port0_mask),
    parameter logic [ADDR_WIDTH-1:0] PORT1_BASE = ADDR_WIDTH'(c_port1_base),
    parameter logic [ADDR_WIDTH-1:0] PORT1_MASK = ADDR_WIDTH'(c_port1_mask)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit0,
    output logic                  o_hit1,
    output logic                  o_unmapped
);

    logic w_match0;
    logic w_match1;

    assign w_match0   = (i_addr & PORT0_MASK) == PORT0_BASE;
    assign w_match1   = (i_addr & PORT1_MASK) == PORT1_BASE;

    // Overlapping regions resolve to port 0.
    assign o_hit0     = w_match0;
    assign o_hit1     = ~w_match0 & w_match1;
    assign o_unmapped = ~(w_match0 | w_match1);

endmodule

`default_nettype wire

// File: rtl/ahb_input_stage_dma.sv
// ============================================================================
// ahb_input_stage_dma : registered AHB input stage for the DMA master port
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_input_stage_dma
    import ahb_bm_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PORT0_BASE = ADDR_WIDTH'(c_port0_base),
    parameter logic [ADDR_WIDTH-1:0] PORT0_MASK = ADDR_WIDTH'(c_port0_mask),
    parameter logic [ADDR_WIDTH-1:0] PORT1_BASE = ADDR_WIDTH'(c_port1_base),
    parameter logic [ADDR_WIDTH-1:0] PORT1_MASK = ADDR_WIDTH'(c_port1_mask)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic                  HREADYS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic [31:0]           HRDATAS,
    output logic                  req_port0,
    output logic                  req_port1,
    input  logic                  sel_port0,
    input  logic                  sel_port1,
    input  logic                  HREADYM0,
    input  logic                  HREADYM1,
    input  logic                  HRESPM0,
    input  logic                  HRESPM1,
    input  logic [31:0]           HRDATAM0,
    input  logic [31:0]           HRDATAM1,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [1:0]            trans_out,
    output logic                  write_out,
    output logic [2:0]            size_out,
    output logic [2:0]            burst_out,
    output logic [3:0]            prot_out,
    output logic                  mastlock_out
);

    ism_state_e            r_state_q, w_state_d, w_branch;
    logic                  r_port_q,  w_port_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  w_addr_d;
    logic                  r_write_q, w_write_d;
    logic [2:0]            r_size_q,  w_size_d;
    logic [3:0]            r_prot_q,  w_prot_d;
    logic                  r_lock_q,  w_lock_d;

    logic        w_hit0, w_hit1, w_unmapped, w_accept;
    logic        w_pnd_ready, w_pnd_sel, w_pnd_resp;
    logic [31:0] w_pnd_rdata;
    logic        w_unused;

    ahb_addr_decode_dma #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PORT0_BASE (PORT0_BASE),
        .PORT0_MASK (PORT0_MASK),
        .PORT1_BASE (PORT1_BASE),
        .PORT1_MASK (PORT1_MASK)
    ) u_decode (
        .i_addr     (HADDRS),
        .o_hit0     (w_hit0),
        .o_hit1     (w_hit1),
        .o_unmapped (w_unmapped)
    );

    // Output-side signals of whichever port the held transfer targets.
    assign w_pnd_ready = r_port_q ? HREADYM1 : HREADYM0;
    assign w_pnd_sel   = r_port_q ? sel_port1 : sel_port0;
    assign w_pnd_resp  = r_port_q ? HRESPM1  : HRESPM0;
    assign w_pnd_rdata = r_port_q ? HRDATAM1 : HRDATAM0;

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = c_hresp_okay;
        HRDATAS    = '0;
        case (r_state_q)
            ST_HOLD: HREADYOUTS = 1'b0;
            ST_DATA: begin
                HREADYOUTS = w_pnd_ready;
                HRESPS     = w_pnd_resp;
                HRDATAS    = w_pnd_rdata;
            end
            ST_ERR1: begin
                HREADYOUTS = 1'b0;
                HRESPS     = c_hresp_error;
            end
            ST_ERR2: HRESPS = c_hresp_error;
            default: ;
        endcase
    end

    assign w_accept = HSELS & HTRANSS[1] & HREADYS & HREADYOUTS;

    always_comb begin
        w_state_d = r_state_q;
        w_port_d  = r_port_q;
        w_addr_d  = r_addr_q;
        w_write_d = r_write_q;
        w_size_d  = r_size_q;
        w_prot_d  = r_prot_q;
        w_lock_d  = r_lock_q;
        w_branch  = ST_IDLE;

        if (w_accept) begin
            w_branch  = w_unmapped ? ST_ERR1 : ST_HOLD;
            w_addr_d  = HADDRS;
            w_write_d = HWRITES;
            w_size_d  = HSIZES;
            w_prot_d  = HPROTS;
            w_lock_d  = HMASTLOCKS;
            if (!w_unmapped) begin
                w_port_d = w_hit1;
            end
        end

        case (r_state_q)
            ST_IDLE, ST_ERR2: w_state_d = w_branch;
            ST_HOLD: if (w_pnd_sel && w_pnd_ready) w_state_d = ST_DATA;
            ST_DATA: if (w_pnd_ready) w_state_d = w_branch;
            ST_ERR1: w_state_d = ST_ERR2;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state_q <= ST_IDLE;
            r_port_q  <= 1'b0;
            r_addr_q  <= '0;
            r_write_q <= 1'b0;
            r_size_q  <= '0;
            r_prot_q  <= '0;
            r_lock_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_port_q  <= w_port_d;
            r_addr_q  <= w_addr_d;
            r_write_q <= w_write_d;
            r_size_q  <= w_size_d;
            r_prot_q  <= w_prot_d;
            r_lock_q  <= w_lock_d;
        end
    end

    assign req_port0    = (r_state_q == ST_HOLD) & ~r_port_q;
    assign req_port1    = (r_state_q == ST_HOLD) &  r_port_q;
    assign trans_out    = (r_state_q == ST_HOLD) ? c_htrans_nonseq : c_htrans_idle;
    // Bursts are flattened into single beats so the arbiter may re-grant between them.
    assign burst_out    = c_hburst_single;
    assign addr_out     = r_addr_q;
    assign write_out    = r_write_q;
    assign size_out     = r_size_q;
    assign prot_out     = r_prot_q;
    assign mastlock_out = r_lock_q;

    assign w_unused = ^{HTRANSS[0], w_hit0};

endmodule

`default_nettype wire
